mem_copy: RTL and testbench
===========================

# mem_copy

Word-granular block-copy engine acting as an initiator on the CPU-style memory port (`mem_re`, `mem_we`, `memaddr`, `rmemdata`, `wmemdata`). It reads `len` 32-bit words from a source word address and writes them to a destination word address on the same port, which it drives in place of, or arbitrated alongside, the CPU. It is used for boot-time program relocation and memory fill/verify. A running 32-bit checksum of the transferred data is exposed for self-check.

## Interface
- `AWIDTH`, 30: word-address width of the memory port.
- `LWIDTH`, 16: width of the length field, in words.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `abort`  in  1  cancel the transfer in progress; sampled only while busy.
- `src_addr`  in  AWIDTH  first source word address, latched on accepted `start`.
- `dst_addr`  in  AWIDTH  first destination word address, latched on accepted `start`.
- `len`  in  LWIDTH  word count, latched on accepted `start`; 0 is legal.
- `busy`  out  1  transfer in progress.
- `done`  out  1  one-cycle pulse on normal completion.
- `checksum`  out  32  sum mod 2^32 of all words written since last accepted `start`.
- `mem_re`  out  1  read strobe.
- `mem_we`  out  1  write strobe.
- `memaddr`  out  AWIDTH  word address.
- `rmemdata`  in  32  read data, valid the cycle after the `mem_re` cycle.
- `wmemdata`  out  32  write data.

## Operation
- States: IDLE, READ, CAPT, WRITE, DONE.
- IDLE: `start`=1 latches `src`/`dst`/`len`, sets a word counter to `len`, and clears `checksum`. If `len`=0, go to DONE; otherwise go to READ.
- READ: `mem_re`=1, `memaddr`=current src. Go to CAPT.
- CAPT: no strobes. `data_q`<=`rmemdata`. Go to WRITE.
- WRITE: `mem_we`=1, `memaddr`=current dst, `wmemdata`=`data_q`, `checksum`+=`data_q`.
  - src and dst each increment by 1, modulo 2^AWIDTH; wrap from all-ones to 0 is silent.
  - Counter decrements. If it reaches 0, go to DONE; otherwise go to READ.
- DONE: `done`=1 for one cycle, then IDLE.
- `abort` while in READ/CAPT/WRITE: the current cycle completes as described, then the block enters IDLE next cycle.
  - No `done` pulse.
  - `checksum` holds the words actually written.
- `start` while not in IDLE is ignored; latched parameters are unaffected.
- `abort` and `start` are both ignored in IDLE and DONE.
- `mem_re` and `mem_we` are never both high.
- While in IDLE or DONE, `memaddr` and `wmemdata` are held at 0.
- Asynchronous reset, immediately and from any state:
  - state←IDLE.
  - `busy`, `done`, `mem_re`, `mem_we`=0.
  - `memaddr`, `wmemdata`, `checksum`=0; internal registers=0.
  - A partially completed copy is abandoned; there is no resume.

## Timing
- Accepted `start` at edge E0 (IDLE). `busy`=1 from the cycle after E0 until the cycle of the final WRITE inclusive. `busy`=0 in DONE and IDLE.
- Cycles are numbered from the first cycle after E0 as cycle 1:
  - Word k (k=0..len−1) occupies READ in cycle 3k+1, CAPT in cycle 3k+2, WRITE in cycle 3k+3.
  - `done` is high in cycle 3·len+1. With `len`=0, `done` is high in cycle 1 and no strobes are issued.
- Throughput: 3 cycles per word. A new `start` is accepted at the earliest in the cycle after DONE.
- All outputs are registered (Moore); there is no combinational path from `rmemdata`, `start` or `abort` to any output.
- The responder must register the read address on the rising edge ending the READ cycle and present data before the rising edge ending CAPT.

## Test plan
- Basic copy: memory[0x10..0x13] = 0x11111111, 0x22222222, 0x33333333, 0x44444444; `start` with src=0x10, dst=0x80, len=4.
  - memory[0x80..0x83] equals the source.
  - `done` pulses exactly 13 cycles after the `start` edge.
  - `checksum`=0xAAAAAAAA.
  - Exactly 4 `mem_re` and 4 `mem_we` cycles, never overlapping.
- Zero length: `start` with len=0 → `done` high in cycle 1, `busy` never high, no strobes, `checksum`=0.
- Address wrap: src=0x3FFFFFFF, dst=0x3FFFFFFE, len=3.
  - Reads hit 0x3FFFFFFF, 0x0, 0x1.
  - Writes hit 0x3FFFFFFE, 0x3FFFFFFF, 0x0.
  - Source values (0xA, 0xB, 0xC) land correctly and `checksum`=0x21.
- Start while busy: second `start` (src=0x40, len=9) in cycle 5 of a len=4 copy.
  - It is ignored; the transfer completes as in the basic copy.
  - The block returns to IDLE and a third `start` is then accepted.
- Abort: `abort` in cycle 5 (CAPT of word 1) of the basic copy.
  - Words 0 and 1 are written; no write to 0x82.
  - `busy` falls in cycle 7 and `done` never pulses.
  - `checksum`=0x33333333.
- Reset mid-operation: drive `rst_n` low in cycle 3 (WRITE) of the basic copy.
  - All outputs drop to 0 without waiting for a clock edge; no further strobes.
  - After release, the block sits in IDLE and a fresh `start` copies correctly.

Source files
------------

// File: rtl/mem_copy.sv
// Word-granular block-copy engine on the CPU-style memory port.
// Three cycles per word (READ, CAPT, WRITE) with a running checksum.
module mem_copy #(
  parameter int AWIDTH = 30,
  parameter int LWIDTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [AWIDTH-1:0] src_addr,
  input  logic [AWIDTH-1:0] dst_addr,
  input  logic [LWIDTH-1:0] len,
  output logic              busy,
  output logic              done,
  output logic [31:0]       checksum,
  output logic              mem_re,
  output logic              mem_we,
  output logic [AWIDTH-1:0] memaddr,
  input  logic [31:0]       rmemdata,
  output logic [31:0]       wmemdata
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_CAPT  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [AWIDTH-1:0] src_q, src_d;
  logic [AWIDTH-1:0] dst_q, dst_d;
  logic [LWIDTH-1:0] cnt_q, cnt_d;
  logic [31:0]       data_q, data_d;
  logic [31:0]       sum_q, sum_d;
  logic              abort_q, abort_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              re_q, re_d;
  logic              we_q, we_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              run;

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    sum_d   = sum_q;
    run     = (state_q == S_READ) || (state_q == S_CAPT)
           || (state_q == S_WRITE);
    // Abort is registered, so the cycle in flight still completes.
    abort_d = abort && run;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          src_d   = src_addr;
          dst_d   = dst_addr;
          cnt_d   = len;
          sum_d   = '0;
          state_d = (len == '0) ? S_DONE : S_READ;
        end
      end
      S_READ: state_d = abort_q ? S_IDLE : S_CAPT;
      S_CAPT: begin
        data_d  = rmemdata;
        state_d = abort_q ? S_IDLE : S_WRITE;
      end
      S_WRITE: begin
        sum_d = sum_q + data_q;
        src_d = src_q + AWIDTH'(1);
        dst_d = dst_q + AWIDTH'(1);
        cnt_d = cnt_q - LWIDTH'(1);
        if (abort_q)
          state_d = S_IDLE;
        else if (cnt_q == LWIDTH'(1))
          state_d = S_DONE;
        else
          state_d = S_READ;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from next-state values into flops.
  always_comb begin
    busy_d  = (state_d == S_READ) || (state_d == S_CAPT)
           || (state_d == S_WRITE);
    done_d  = (state_d == S_DONE);
    re_d    = (state_d == S_READ);
    we_d    = (state_d == S_WRITE);
    addr_d  = '0;
    wdata_d = '0;
    if (re_d)
      addr_d = src_d;
    if (we_d) begin
      addr_d  = dst_d;
      wdata_d = data_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      sum_q   <= '0;
      abort_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      re_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      sum_q   <= sum_d;
      abort_q <= abort_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      re_q    <= re_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign checksum = sum_q;
  assign mem_re   = re_q;
  assign mem_we   = we_q;
  assign memaddr  = addr_q;
  assign wmemdata = wdata_q;

endmodule

// File: tb/tb_mem_copy.sv
// Directed bench for mem_copy with a behavioural memory responder.
// Checks strobes, addresses, timing, checksum, abort and reset.
module tb_mem_copy;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [29:0] src_addr = '0;
  logic [29:0] dst_addr = '0;
  logic [15:0] len = '0;
  logic        busy, done, mem_re, mem_we;
  logic [31:0] checksum, wmemdata;
  logic [31:0] rmemdata = '0;
  logic [29:0] memaddr;

  int compared = 0;
  int mismatched = 0;

  logic [31:0] mem [logic [29:0]];
  int re_n = 0, we_n = 0, ovl_n = 0;
  logic [29:0] re_q[$];
  logic [29:0] we_q[$];

  mem_copy #(.AWIDTH(30), .LWIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
    .busy(busy), .done(done), .checksum(checksum),
    .mem_re(mem_re), .mem_we(mem_we), .memaddr(memaddr),
    .rmemdata(rmemdata), .wmemdata(wmemdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_re)
      rmemdata <= mem.exists(memaddr) ? mem[memaddr] : 32'h0;
    if (mem_we)
      mem[memaddr] = wmemdata;
  end

  always @(negedge clk) begin
    if (mem_re) begin re_n++; re_q.push_back(memaddr); end
    if (mem_we) begin we_n++; we_q.push_back(memaddr); end
    if (mem_re && mem_we) ovl_n++;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rd(input logic [29:0] a);
    return mem.exists(a) ? mem[a] : 32'hDEAD_BEEF;
  endfunction

  task automatic run(input logic [29:0] s, input logic [29:0] d,
                     input logic [15:0] l, input int abort_cyc,
                     input int start2_cyc, input int maxc,
                     output int done_cyc, output int busy_fall,
                     output int busy_any);
    logic pb;
    @(negedge clk);
    re_n = 0; we_n = 0; ovl_n = 0;
    re_q.delete(); we_q.delete();
    src_addr = s; dst_addr = d; len = l; start = 1'b1;
    done_cyc = -1; busy_fall = -1; busy_any = 0; pb = 1'b0;
    for (int c = 1; c <= maxc; c++) begin
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      if (done && done_cyc < 0) done_cyc = c;
      if (busy) busy_any = 1;
      if (pb && !busy && busy_fall < 0) busy_fall = c;
      pb = busy;
      if (c == start2_cyc) begin
        start = 1'b1; src_addr = 30'h40; len = 16'd9;
      end
      if (c == abort_cyc) abort = 1'b1;
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  int dc, bf, ba;

  initial begin
    #2;
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_done", {31'b0, done}, 32'h0);
    check("rst_re", {31'b0, mem_re}, 32'h0);
    check("rst_we", {31'b0, mem_we}, 32'h0);
    check("rst_addr", {2'b0, memaddr}, 32'h0);
    check("rst_wdata", wmemdata, 32'h0);
    check("rst_sum", checksum, 32'h0);
    mem[30'h10] = 32'h1111_1111;
    mem[30'h11] = 32'h2222_2222;
    mem[30'h12] = 32'h3333_3333;
    mem[30'h13] = 32'h4444_4444;
    @(negedge clk);
    rst_n = 1'b1;

    // Basic copy
    run(30'h10, 30'h80, 16'd4, -1, -1, 16, dc, bf, ba);
    check("basic_m80", rd(30'h80), 32'h1111_1111);
    check("basic_m81", rd(30'h81), 32'h2222_2222);
    check("basic_m82", rd(30'h82), 32'h3333_3333);
    check("basic_m83", rd(30'h83), 32'h4444_4444);
    check("basic_done_cyc", dc, 32'd13);
    check("basic_busy_fall", bf, 32'd13);
    check("basic_sum", checksum, 32'hAAAA_AAAA);
    check("basic_re_n", re_n, 32'd4);
    check("basic_we_n", we_n, 32'd4);
    check("basic_overlap", ovl_n, 32'd0);
    check("basic_raddr2", {2'b0, re_q[2]}, 32'h12);
    check("basic_waddr3", {2'b0, we_q[3]}, 32'h83);

    // Zero length
    run(30'h10, 30'h90, 16'd0, -1, -1, 5, dc, bf, ba);
    check("zero_done_cyc", dc, 32'd1);
    check("zero_busy", ba, 32'd0);
    check("zero_strobes", re_n + we_n, 32'd0);
    check("zero_sum", checksum, 32'h0);

    // Address wrap
    mem[30'h3FFF_FFFF] = 32'hA;
    mem[30'h0] = 32'hB;
    mem[30'h1] = 32'hC;
    run(30'h3FFF_FFFF, 30'h3FFF_FFFE, 16'd3, -1, -1, 12, dc, bf, ba);
    check("wrap_done_cyc", dc, 32'd10);
    check("wrap_r0", {2'b0, re_q[0]}, 32'h3FFF_FFFF);
    check("wrap_r1", {2'b0, re_q[1]}, 32'h0);
    check("wrap_r2", {2'b0, re_q[2]}, 32'h1);
    check("wrap_w0", {2'b0, we_q[0]}, 32'h3FFF_FFFE);
    check("wrap_w1", {2'b0, we_q[1]}, 32'h3FFF_FFFF);
    check("wrap_w2", {2'b0, we_q[2]}, 32'h0);
    check("wrap_mFE", rd(30'h3FFF_FFFE), 32'hA);
    check("wrap_mFF", rd(30'h3FFF_FFFF), 32'hB);
    check("wrap_m0", rd(30'h0), 32'hC);
    check("wrap_sum", checksum, 32'h21);

    // Start while busy
    for (int i = 0; i < 4; i++) mem[30'h80 + 30'(i)] = 32'h0;
    run(30'h10, 30'h80, 16'd4, -1, 5, 16, dc, bf, ba);
    check("sb_done_cyc", dc, 32'd13);
    check("sb_sum", checksum, 32'hAAAA_AAAA);
    check("sb_re_n", re_n, 32'd4);
    check("sb_raddr3", {2'b0, re_q[3]}, 32'h13);
    check("sb_m83", rd(30'h83), 32'h4444_4444);
    run(30'h11, 30'h90, 16'd1, -1, -1, 6, dc, bf, ba);
    check("sb3_done_cyc", dc, 32'd4);
    check("sb3_m90", rd(30'h90), 32'h2222_2222);
    check("sb3_sum", checksum, 32'h2222_2222);

    // Abort during CAPT of word 1
    for (int i = 0; i < 4; i++) mem[30'h80 + 30'(i)] = 32'h0;
    run(30'h10, 30'h80, 16'd4, 5, -1, 14, dc, bf, ba);
    check("ab_done", dc, 32'hFFFF_FFFF);
    check("ab_busy_fall", bf, 32'd7);
    check("ab_we_n", we_n, 32'd2);
    check("ab_m81", rd(30'h81), 32'h2222_2222);
    check("ab_m82", rd(30'h82), 32'h0);
    check("ab_sum", checksum, 32'h3333_3333);

    // Reset in cycle 3 (WRITE of word 0)
    mem[30'h80] = 32'h0;
    @(negedge clk);
    re_n = 0; we_n = 0;
    src_addr = 30'h10; dst_addr = 30'h80; len = 16'd4; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2;
    check("pre_rst_we", {31'b0, mem_we}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("mrst_we", {31'b0, mem_we}, 32'h0);
    check("mrst_busy", {31'b0, busy}, 32'h0);
    check("mrst_addr", {2'b0, memaddr}, 32'h0);
    check("mrst_wdata", wmemdata, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("mrst_we_n", we_n, 32'd1);
    check("mrst_m80", rd(30'h80), 32'h0);
    check("mrst_idle", {31'b0, busy}, 32'h0);
    run(30'h10, 30'hA0, 16'd4, -1, -1, 16, dc, bf, ba);
    check("post_done_cyc", dc, 32'd13);
    check("post_mA0", rd(30'hA0), 32'h1111_1111);
    check("post_mA3", rd(30'hA3), 32'h4444_4444);
    check("post_sum", checksum, 32'hAAAA_AAAA);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
